fpu_mmio_sequencer: RTL and testbench



---
 rtl/fpu_mmio_pkg.sv | 37 +++
 rtl/fpu_mmio_regfile.sv | 107 ++++++++++
 rtl/fpu_mmio_sequencer.sv | 148 ++++++++++++++
 tb/tb_fpu_mmio_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mmio_pkg.sv
// Shared definitions for the FPU MMIO sequencer: register offsets, bit positions,
// sequencer states and the FPU opcode set.
package fpu_mmio_pkg;

  localparam logic [2:0] OFF_OPA    = 3'd0;
  localparam logic [2:0] OFF_OPB    = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_RESULT = 3'd4;

  localparam int CTRL_IE_BIT    = 3;
  localparam int CTRL_START_BIT = 8;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_TIMEOUT_BIT = 2;
  localparam int STAT_WWB_BIT     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT
  } seq_state_e;

  typedef enum logic [2:0] {
    FPU_ADD  = 3'd0,
    FPU_SUB  = 3'd1,
    FPU_MUL  = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_SQRT = 3'd4,
    FPU_CMP  = 3'd5,
    FPU_I2F  = 3'd6,
    FPU_F2I  = 3'd7
  } fpu_op_e;

endpackage

// File: rtl/fpu_mmio_regfile.sv
// CPU-facing register file: window decode, byte-merged OPA/OPB, CTRL fields and
// the registered read mux. Config writes are refused while the sequencer is busy.
module fpu_mmio_regfile
  import fpu_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hF000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] rd_addr,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_en,
  input  logic        busy,
  input  logic [3:0]  status,
  input  logic [31:0] result,
  output logic [31:0] rd_data,
  output logic [31:0] opa,
  output logic [31:0] opb,
  output logic [2:0]  ctrl_op,
  output logic        ctrl_ie,
  output logic        start_req,
  output logic        wr_busy_hit
);

  logic        wr_in_win;
  logic        rd_in_win;
  logic [2:0]  wr_off;
  logic [2:0]  rd_off;
  logic        wr_cfg;
  logic        wr_ok;
  logic        unused_addr_lsbs;

  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  ctrl_op_q, ctrl_op_d;
  logic        ctrl_ie_q, ctrl_ie_d;
  logic [31:0] rd_data_q, rd_data_d;

  assign wr_in_win = (wr_addr[31:5] == BASE_ADDR[31:5]);
  assign rd_in_win = (rd_addr[31:5] == BASE_ADDR[31:5]);
  assign wr_off    = wr_addr[4:2];
  assign rd_off    = rd_addr[4:2];
  assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

  // Any byte-enabled write aimed at OPA/OPB/CTRL; only accepted when idle.
  assign wr_cfg      = wr_in_win && (wr_off <= OFF_CTRL) && (|wr_en);
  assign wr_ok       = wr_cfg && !busy;
  assign wr_busy_hit = wr_cfg && busy;
  assign start_req   = wr_ok && (wr_off == OFF_CTRL) && wr_en[1] && wr_data[CTRL_START_BIT];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_merge
      assign opa_d[gi*8 +: 8] = (wr_ok && (wr_off == OFF_OPA) && wr_en[gi])
                                ? wr_data[gi*8 +: 8] : opa_q[gi*8 +: 8];
      assign opb_d[gi*8 +: 8] = (wr_ok && (wr_off == OFF_OPB) && wr_en[gi])
                                ? wr_data[gi*8 +: 8] : opb_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    ctrl_op_d = ctrl_op_q;
    ctrl_ie_d = ctrl_ie_q;
    if (wr_ok && (wr_off == OFF_CTRL) && wr_en[0]) begin
      ctrl_op_d = wr_data[2:0];
      ctrl_ie_d = wr_data[CTRL_IE_BIT];
    end
  end

  // Read mux samples current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_data_d = '0;
    if (rd_in_win) begin
      case (rd_off)
        OFF_OPA:    rd_data_d = opa_q;
        OFF_OPB:    rd_data_d = opb_q;
        OFF_CTRL:   rd_data_d = {28'd0, ctrl_ie_q, ctrl_op_q};
        OFF_STATUS: rd_data_d = {28'd0, status};
        OFF_RESULT: rd_data_d = result;
        default:    rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opa_q     <= '0;
      opb_q     <= '0;
      ctrl_op_q <= '0;
      ctrl_ie_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      ctrl_op_q <= ctrl_op_d;
      ctrl_ie_q <= ctrl_ie_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign opa     = opa_q;
  assign opb     = opb_q;
  assign ctrl_op = ctrl_op_q;
  assign ctrl_ie = ctrl_ie_q;

endmodule

// File: rtl/fpu_mmio_sequencer.sv
// MMIO front end for the shared FPU: issues the A/B operand beats, waits for done
// under a timeout, captures the result and reports status / interrupt.
module fpu_mmio_sequencer
  import fpu_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'hF000_0000,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          CNT_W          = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] io_rdAddress,
  output logic [31:0] io_rdData,
  input  logic [31:0] io_wrAddress,
  input  logic [31:0] io_wrData,
  input  logic [3:0]  io_wrEnable,
  output logic [2:0]  io_fpu_op,
  output logic        io_fpu_start,
  output logic [31:0] io_fpu_ab,
  input  logic [31:0] io_fpu_result,
  input  logic        io_fpu_done,
  output logic        io_irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             wwb_q, wwb_d;

  logic             busy;
  logic [3:0]       status;
  logic [31:0]      opa;
  logic [31:0]      opb;
  logic [2:0]       ctrl_op;
  logic             ctrl_ie;
  logic             start_req;
  logic             wr_busy_hit;
  logic             fpu_start;
  logic [31:0]      fpu_ab;

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    status                   = '0;
    status[STAT_BUSY_BIT]    = busy;
    status[STAT_DONE_BIT]    = done_q;
    status[STAT_TIMEOUT_BIT] = timeout_q;
    status[STAT_WWB_BIT]     = wwb_q;
  end

  fpu_mmio_regfile #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regfile (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd_addr     (io_rdAddress),
    .wr_addr     (io_wrAddress),
    .wr_data     (io_wrData),
    .wr_en       (io_wrEnable),
    .busy        (busy),
    .status      (status),
    .result      (result_q),
    .rd_data     (io_rdData),
    .opa         (opa),
    .opb         (opb),
    .ctrl_op     (ctrl_op),
    .ctrl_ie     (ctrl_ie),
    .start_req   (start_req),
    .wr_busy_hit (wr_busy_hit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    wwb_d     = wwb_q;
    fpu_start = 1'b0;
    fpu_ab    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d   = ST_SEND_A;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          wwb_d     = 1'b0;
        end
      end
      ST_SEND_A: begin
        fpu_start = 1'b1;
        fpu_ab    = opa;
        state_d   = ST_SEND_B;
      end
      ST_SEND_B: begin
        fpu_ab  = opb;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the last counted cycle still wins over timeout.
        if (io_fpu_done) begin
          result_d = io_fpu_result;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_busy_hit) begin
      wwb_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wwb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      wwb_q     <= wwb_d;
    end
  end

  assign io_fpu_start = fpu_start;
  assign io_fpu_ab    = fpu_ab;
  assign io_fpu_op    = ctrl_op;
  assign io_irq       = done_q && ctrl_ie;

endmodule

// File: tb/tb_fpu_mmio_sequencer.sv
// Self-checking bench for fpu_mmio_sequencer: directed scenarios plus randomized
// operations checked against a register-level reference model.
module tb_fpu_mmio_sequencer;

  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] io_rdAddress;
  logic [31:0] io_rdData;
  logic [31:0] io_wrAddress;
  logic [31:0] io_wrData;
  logic [3:0]  io_wrEnable;
  logic [2:0]  io_fpu_op;
  logic        io_fpu_start;
  logic [31:0] io_fpu_ab;
  logic [31:0] io_fpu_result;
  logic        io_fpu_done;
  logic        io_irq;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural register contents only.
  logic [31:0] m_opa, m_opb, m_result;
  logic [2:0]  m_op;
  logic        m_ie, m_busy, m_done, m_to, m_wwb;

  always #5 clock = ~clock;

  fpu_mmio_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .io_rdAddress  (io_rdAddress),
    .io_rdData     (io_rdData),
    .io_wrAddress  (io_wrAddress),
    .io_wrData     (io_wrData),
    .io_wrEnable   (io_wrEnable),
    .io_fpu_op     (io_fpu_op),
    .io_fpu_start  (io_fpu_start),
    .io_fpu_ab     (io_fpu_ab),
    .io_fpu_result (io_fpu_result),
    .io_fpu_done   (io_fpu_done),
    .io_irq        (io_irq)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic m_clear();
    m_opa = 0; m_opb = 0; m_result = 0; m_op = 0;
    m_ie = 0; m_busy = 0; m_done = 0; m_to = 0; m_wwb = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a[31:5] == BASE[31:5]) begin
      case (a[4:2])
        3'd0: v = m_opa;
        3'd1: v = m_opb;
        3'd2: v = {28'd0, m_ie, m_op};
        3'd3: v = {28'd0, m_wwb, m_to, m_done, m_busy};
        3'd4: v = m_result;
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (a[31:5] == BASE[31:5] && a[4:2] <= 3'd2 && be != 4'd0) begin
      if (m_busy) begin
        m_wwb = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (be[i] && a[4:2] == 3'd0) m_opa[i*8 +: 8] = d[i*8 +: 8];
          if (be[i] && a[4:2] == 3'd1) m_opb[i*8 +: 8] = d[i*8 +: 8];
        end
        if (a[4:2] == 3'd2) begin
          if (be[0]) begin
            m_op = d[2:0];
            m_ie = d[3];
          end
          if (be[1] && d[8]) begin
            m_busy = 1'b1; m_done = 1'b0; m_to = 1'b0; m_wwb = 1'b0;
          end
        end
      end
    end
  endtask

  // One bus cycle: read address and optional write presented together.
  task automatic bus(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] exp_rd, output logic [31:0] got_rd);
    io_rdAddress = ra;
    io_wrAddress = wa;
    io_wrData    = wd;
    io_wrEnable  = be;
    exp_rd = m_read(ra);
    model_write(wa, wd, be);
    cyc();
    got_rd = io_rdData;
    io_wrEnable = 4'd0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] ra);
    logic [31:0] e, g;
    bus(ra, 32'd0, 32'd0, 4'd0, e, g);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: read @%h got %h expected %h", name, ra, g, e);
    end
  endtask

  // Start an operation from IDLE and play the FPU side; done arrives `delay`
  // cycles into the wait phase, or never if delay >= 64.
  task automatic run_op(input string tag, input logic [2:0] op, input logic ie, input int delay,
                        input logic [31:0] res, input logic stray);
    logic [31:0] e, g;
    logic        fin;
    bus(BASE + 32'hC, BASE + 32'h8, {23'd0, 1'b1, 4'd0, ie, op}, 4'b0011, e, g);
    total++;
    if (g !== e) begin bad++; $display("FAIL %s status_at_start: got %h expected %h", tag, g, e); end
    total++;
    if (io_fpu_start !== 1'b1 || io_fpu_ab !== m_opa || io_fpu_op !== m_op) begin
      bad++;
      $display("FAIL %s a_beat: got start=%b ab=%h op=%0d expected start=1 ab=%h op=%0d",
               tag, io_fpu_start, io_fpu_ab, io_fpu_op, m_opa, m_op);
    end
    total++;
    if (io_irq !== 1'b0) begin bad++; $display("FAIL %s irq_after_start: got %b expected 0", tag, io_irq); end
    cyc();
    total++;
    if (io_fpu_start !== 1'b0 || io_fpu_ab !== m_opb) begin
      bad++;
      $display("FAIL %s b_beat: got start=%b ab=%h expected start=0 ab=%h", tag, io_fpu_start, io_fpu_ab, m_opb);
    end
    cyc();
    total++;
    if (io_fpu_start !== 1'b0 || io_fpu_ab !== 32'd0) begin
      bad++;
      $display("FAIL %s wait_bus: got start=%b ab=%h expected start=0 ab=0", tag, io_fpu_start, io_fpu_ab);
    end
    fin = 1'b0;
    for (int k = 0; k < 64 && !fin; k++) begin
      if (k == delay) begin
        io_fpu_done = 1'b1;
        io_fpu_result = res;
        cyc();
        io_fpu_done = 1'b0;
        io_fpu_result = $urandom;
        m_result = res; m_done = 1'b1; m_busy = 1'b0;
        fin = 1'b1;
      end else if (stray && k == 2) begin
        bus(BASE + 32'hC, BASE + 32'h0, 32'hDEAD_BEEF, 4'hF, e, g);
        total++;
        if (g !== e) begin bad++; $display("FAIL %s busy_status: got %h expected %h", tag, g, e); end
      end else begin
        cyc();
      end
    end
    if (!fin) begin
      m_to = 1'b1; m_busy = 1'b0;
    end
    total++;
    if (io_irq !== (m_done && m_ie)) begin
      bad++;
      $display("FAIL %s irq_after_end: got %b expected %b", tag, io_irq, m_done && m_ie);
    end
    rd_check({tag, " status"}, BASE + 32'hC);
    rd_check({tag, " result"}, BASE + 32'h10);
    $display("op %s: op=%0d ie=%0d delay=%0d stray=%0d status=%h result=%h",
             tag, op, ie, delay, stray, m_read(BASE + 32'hC), m_result);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    io_rdAddress = 0; io_wrAddress = 0; io_wrData = 0; io_wrEnable = 0;
    io_fpu_result = 0; io_fpu_done = 0;
    m_clear();
    repeat (3) cyc();
    total++;
    if (io_rdData !== 32'd0 || io_fpu_start !== 1'b0 || io_fpu_ab !== 32'd0 ||
        io_fpu_op !== 3'd0 || io_irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rd=%h start=%b ab=%h op=%0d irq=%b expected all 0",
               io_rdData, io_fpu_start, io_fpu_ab, io_fpu_op, io_irq);
    end
    reset_n = 1'b1;
    cyc();
    rd_check("reset status", BASE + 32'hC);
    rd_check("reset opa", BASE + 32'h0);
    rd_check("reset ctrl", BASE + 32'h8);
    $display("reset: done");
  endtask

  task automatic test_basic();
    logic [31:0] e, g;
    bus(0, BASE + 32'h0, 32'h3F80_0000, 4'hF, e, g);
    bus(0, BASE + 32'h4, 32'h4000_0000, 4'hF, e, g);
    run_op("basic", 3'd1, 1'b0, 3, 32'h4040_0000, 1'b0);
    bus(BASE + 32'h10, 0, 0, 0, e, g);
    total++;
    if (g !== 32'h4040_0000) begin bad++; $display("FAIL basic result_const: got %h expected 40400000", g); end
    bus(BASE + 32'hC, 0, 0, 0, e, g);
    total++;
    if (g !== 32'h2) begin bad++; $display("FAIL basic status_const: got %h expected 2", g); end
  endtask

  task automatic test_irq();
    logic [31:0] e, g;
    bus(0, BASE + 32'h8, 32'h0000_0009, 4'b0001, e, g);
    total++;
    if (io_irq !== 1'b1) begin bad++; $display("FAIL irq_enable_old_done: got %b expected 1", io_irq); end
    run_op("irq", 3'd1, 1'b1, 3, 32'h4040_0000, 1'b0);
    repeat (3) cyc();
    total++;
    if (io_irq !== 1'b1) begin bad++; $display("FAIL irq_hold: got %b expected 1", io_irq); end
  endtask

  task automatic test_timeout();
    logic [31:0] e, g;
    logic [31:0] prev;
    prev = m_result;
    run_op("timeout", 3'd2, 1'b1, 1000, 32'h1111_1111, 1'b0);
    bus(BASE + 32'hC, 0, 0, 0, e, g);
    total++;
    if (g !== 32'h4) begin bad++; $display("FAIL timeout status_const: got %h expected 4", g); end
    io_fpu_done = 1'b1; io_fpu_result = 32'h5555_5555;
    cyc();
    io_fpu_done = 1'b0;
    bus(BASE + 32'h10, 0, 0, 0, e, g);
    total++;
    if (g !== prev) begin bad++; $display("FAIL timeout result_kept: got %h expected %h", g, prev); end
    rd_check("idle_done status", BASE + 32'hC);
  endtask

  task automatic test_wr_busy();
    logic [31:0] e, g;
    logic [31:0] prev_opa;
    prev_opa = m_opa;
    run_op("wr_busy", 3'd3, 1'b0, 10, 32'h2222_2222, 1'b1);
    bus(BASE + 32'h0, 0, 0, 0, e, g);
    total++;
    if (g !== prev_opa) begin bad++; $display("FAIL wr_busy opa_kept: got %h expected %h", g, prev_opa); end
    bus(BASE + 32'hC, 0, 0, 0, e, g);
    total++;
    if (g !== 32'hA) begin bad++; $display("FAIL wr_busy status_const: got %h expected a", g); end
    run_op("wr_busy_clear", 3'd3, 1'b0, 5, 32'h3333_3333, 1'b0);
  endtask

  task automatic test_bytes();
    logic [31:0] e, g;
    bus(0, BASE + 32'h4, 32'h0, 4'hF, e, g);
    bus(BASE + 32'h4, BASE + 32'h4, 32'h0000_AB00, 4'b0010, e, g);
    total++;
    if (g !== 32'h0) begin bad++; $display("FAIL rd_during_wr: got %h expected 0", g); end
    bus(BASE + 32'h4, 0, 0, 0, e, g);
    total++;
    if (g !== 32'h0000_AB00) begin bad++; $display("FAIL byte_opb: got %h expected 0000ab00", g); end
    bus(BASE + 32'h1C, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, e, g);
    total++;
    if (g !== 32'h0) begin bad++; $display("FAIL read_1c: got %h expected 0", g); end
    bus(0, 32'hE000_0000, 32'h1234_5678, 4'hF, e, g);
    bus(0, BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, e, g);
    bus(0, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, e, g);
    rd_check("outside opa", BASE + 32'h0);
    rd_check("offset14", BASE + 32'h14);
    rd_check("status_ro", BASE + 32'hC);
    rd_check("result_ro", BASE + 32'h10);
    rd_check("outside_read", 32'hE000_000C);
  endtask

  task automatic test_random();
    logic [31:0] e, g;
    int delay;
    logic stray;
    for (int i = 0; i < 12; i++) begin
      bus(0, BASE + 32'h0, $urandom, 4'($urandom_range(1, 15)), e, g);
      bus(0, BASE + 32'h4, $urandom, 4'($urandom_range(1, 15)), e, g);
      case (i % 4)
        0: delay = $urandom_range(0, 10);
        1: delay = $urandom_range(58, 63);
        2: delay = $urandom_range(64, 80);
        default: delay = $urandom_range(0, 63);
      endcase
      stray = (delay > 3) && ($urandom_range(0, 1) == 1);
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             delay, $urandom, stray);
      rd_check("rand opa", BASE + 32'h0);
      rd_check("rand opb", BASE + 32'h4);
      rd_check("rand ctrl", BASE + 32'h8);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e, g;
    bus(0, BASE + 32'h0, 32'h1234_5678, 4'hF, e, g);
    bus(0, BASE + 32'h8, 32'h0000_010D, 4'b0011, e, g);
    total++;
    if (io_fpu_start !== 1'b1 || io_fpu_ab !== 32'h1234_5678) begin
      bad++;
      $display("FAIL mid_a_beat: got start=%b ab=%h expected start=1 ab=12345678", io_fpu_start, io_fpu_ab);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (io_fpu_start !== 1'b0 || io_fpu_ab !== 32'd0 || io_irq !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got start=%b ab=%h irq=%b expected 0", io_fpu_start, io_fpu_ab, io_irq);
    end
    m_clear();
    repeat (2) cyc();
    reset_n = 1'b1;
    io_fpu_done = 1'b1; io_fpu_result = 32'h7777_7777;
    cyc();
    io_fpu_done = 1'b0;
    bus(BASE + 32'hC, 0, 0, 0, e, g);
    total++;
    if (g !== 32'h0) begin bad++; $display("FAIL post_reset status: got %h expected 0", g); end
    rd_check("post_reset result", BASE + 32'h10);
    rd_check("post_reset opa", BASE + 32'h0);
    rd_check("post_reset ctrl", BASE + 32'h8);
    $display("reset_mid: done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_irq();
    test_timeout();
    test_wr_busy();
    test_bytes();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
